// File: rtl/i2c_arbiter_if.sv
// Requester and EEPROM-driver signal bundle for the two-port I2C arbiter.
// slave = arbiter view, master = requesters plus driver view.
interface i2c_arbiter_if;
    logic        req_0;
    logic        req_1;
    logic        rw_0;
    logic        rw_1;
    logic [15:0] addr_0;
    logic [15:0] addr_1;
    logic [7:0]  wdata_0;
    logic [7:0]  wdata_1;
    logic        ack_0;
    logic        ack_1;
    logic        done_0;
    logic        done_1;
    logic        err_0;
    logic        err_1;
    logic [7:0]  rdata_0;
    logic [7:0]  rdata_1;
    logic        busy;
    logic        i2c_start;
    logic        i2c_rw;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic [7:0]  i2c_rdata;

    modport slave (
        input  req_0, req_1, rw_0, rw_1,
        input  addr_0, addr_1, wdata_0, wdata_1,
        output ack_0, ack_1, done_0, done_1,
        output err_0, err_1, rdata_0, rdata_1,
        output busy,
        output i2c_start, i2c_rw, i2c_addr, i2c_wdata,
        input  i2c_done, i2c_rdata
    );

    modport master (
        output req_0, req_1, rw_0, rw_1,
        output addr_0, addr_1, wdata_0, wdata_1,
        input  ack_0, ack_1, done_0, done_1,
        input  err_0, err_1, rdata_0, rdata_1,
        input  busy,
        input  i2c_start, i2c_rw, i2c_addr, i2c_wdata,
        output i2c_done, i2c_rdata
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one EEPROM I2C driver between two ports,
// with transfer timeout, release gap and post-write hold-off.
module i2c_arbiter #(
    parameter int unsigned WR_WAIT_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    i2c_arbiter_if.slave bus
);
    localparam int unsigned MAX_A =
        (WR_WAIT_CYCLES > TIMEOUT_CYCLES) ? WR_WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_P =
        (MAX_A > RELEASE_CYCLES) ? MAX_A : RELEASE_CYCLES;
    localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST  = CW'(WR_WAIT_CYCLES - 1);

    localparam int I_IDLE = 0;
    localparam int I_XFER = 1;
    localparam int I_REL  = 2;
    localparam int I_WR   = 3;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        XFER    = 4'b0010,
        RELEASE = 4'b0100,
        WR_WAIT = 4'b1000
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          done_q;
    logic          win;
    logic          any_req;
    logic          cmpl;

    assign any_req = bus.req_0 | bus.req_1;
    assign cmpl    = bus.i2c_done & ~done_q;
    assign bus.busy = ~state[I_IDLE];

    // last_grant doubles as the owner of the current transfer
    always_comb begin
        win = bus.req_1;
        if (bus.req_0 && bus.req_1)
            win = ~last_grant;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            done_q        <= 1'b0;
            bus.i2c_start <= 1'b0;
            bus.i2c_rw    <= 1'b0;
            bus.i2c_addr  <= '0;
            bus.i2c_wdata <= '0;
            bus.ack_0     <= 1'b0;
            bus.ack_1     <= 1'b0;
            bus.done_0    <= 1'b0;
            bus.done_1    <= 1'b0;
            bus.err_0     <= 1'b0;
            bus.err_1     <= 1'b0;
            bus.rdata_0   <= '0;
            bus.rdata_1   <= '0;
        end else begin
            done_q     <= bus.i2c_done;
            bus.ack_0  <= 1'b0;
            bus.ack_1  <= 1'b0;
            bus.done_0 <= 1'b0;
            bus.done_1 <= 1'b0;
            bus.err_0  <= 1'b0;
            bus.err_1  <= 1'b0;

            unique case (1'b1)
                state[I_IDLE]: begin
                    if (any_req) begin
                        state         <= XFER;
                        cnt           <= '0;
                        last_grant    <= win;
                        bus.i2c_start <= 1'b1;
                        bus.ack_0     <= ~win;
                        bus.ack_1     <= win;
                        bus.i2c_rw    <= win ? bus.rw_1 : bus.rw_0;
                        bus.i2c_addr  <= win ? bus.addr_1 : bus.addr_0;
                        bus.i2c_wdata <= win ? bus.wdata_1 : bus.wdata_0;
                    end
                end

                state[I_XFER]: begin
                    // completion takes priority over a coincident timeout
                    if (cmpl) begin
                        cnt           <= '0;
                        bus.i2c_start <= 1'b0;
                        bus.done_0    <= ~last_grant;
                        bus.done_1    <= last_grant;
                        if (bus.i2c_rw && last_grant)
                            bus.rdata_1 <= bus.i2c_rdata;
                        if (bus.i2c_rw && !last_grant)
                            bus.rdata_0 <= bus.i2c_rdata;
                        state <= bus.i2c_rw ? RELEASE : WR_WAIT;
                    end else if (cnt == TO_LAST) begin
                        cnt           <= '0;
                        bus.i2c_start <= 1'b0;
                        bus.err_0     <= ~last_grant;
                        bus.err_1     <= last_grant;
                        state         <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                state[I_REL]: begin
                    if (cnt == REL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                state[I_WR]: begin
                    if (cnt == WR_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt           <= '0;
                    bus.i2c_start <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
